// File: rtl/jpu_lsu_if.sv
// Request/response and data-bus signal bundle for jpu_lsu.
// slave: the LSU itself. master: the core execute stage plus bus side.
interface jpu_lsu_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned SB_DEPTH = 4
);
    localparam int unsigned OFF = $clog2(DATA_W / 8);
    localparam int unsigned CW  = $clog2(SB_DEPTH) + 1;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [4:0]            req_rd;

    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_data;
    logic [4:0]            resp_rd;
    logic                  resp_err;
    logic                  sb_err;
    logic [CW-1:0]         sb_count;

    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_W-OFF-1:0] bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic [DATA_W/8-1:0]   bus_mask;
    logic                  bus_ack;
    logic [DATA_W-1:0]     bus_rdata;
    logic                  bus_err;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_rd,
        output req_ready,
        output resp_valid, resp_data, resp_rd, resp_err, sb_err, sb_count,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_mask,
        input  bus_ack, bus_rdata, bus_err
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  resp_valid, resp_data, resp_rd, resp_err, sb_err, sb_count,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_mask,
        output bus_ack, bus_rdata, bus_err
    );
endinterface

// File: rtl/jpu_lsu.sv
// jpu_lsu: load/store unit with posted store buffer and load/drain FSM.
// Optional feature: define LSU_STORE_FWD_EN to let loads complete from the
// youngest matching store-buffer entry when it covers every load byte.
module jpu_lsu #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned SB_DEPTH = 4
) (
    input logic     clk,
    input logic     rst,
    jpu_lsu_if.slave lsu
);
    localparam int unsigned NB  = DATA_W / 8;
    localparam int unsigned OFF = $clog2(NB);
    localparam int unsigned PW  = $clog2(SB_DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned WA  = ADDR_W - OFF;

    typedef enum logic [1:0] {IDLE, LD_DRAIN, LD_BUS, LD_RESP} state_t;

    function automatic logic [NB-1:0] lane_mask(input logic [OFF-1:0] lane, input logic [1:0] size);
        logic [NB-1:0] base;
        case (size)
            2'd0:    base = NB'(1);
            2'd1:    base = NB'(3);
            2'd2:    base = NB'(15);
            default: base = '1;
        endcase
        return base << lane;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] raw, input logic [OFF-1:0] lane,
                                                  input logic [1:0] size, input logic sgn);
        logic [DATA_W-1:0] sh, keep;
        logic              sbit;
        sh = raw >> {lane, 3'b000};
        case (size)
            2'd0:    begin keep = DATA_W'(8'hFF);         sbit = sh[7];        end
            2'd1:    begin keep = DATA_W'(16'hFFFF);      sbit = sh[15];       end
            2'd2:    begin keep = DATA_W'(32'hFFFF_FFFF); sbit = sh[31];       end
            default: begin keep = '1;                     sbit = sh[DATA_W-1]; end
        endcase
        return (sgn && sbit) ? (sh | ~keep) : (sh & keep);
    endfunction

    state_t            state_q, state_d;
    logic [WA-1:0]     sb_addr [SB_DEPTH];
    logic [DATA_W-1:0] sb_data [SB_DEPTH];
    logic [NB-1:0]     sb_mask [SB_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     cnt_q;

    logic [WA-1:0]     ld_waddr_q;
    logic [OFF-1:0]    ld_lane_q;
    logic [1:0]        ld_size_q;
    logic              ld_sgn_q;
    logic [4:0]        ld_rd_q;
    logic [DATA_W-1:0] ld_raw_q;
    logic              ld_err_q;

    logic              qr_valid_q, qr_err_q;
    logic [DATA_W-1:0] qr_data_q;
    logic [4:0]        qr_rd_q;
    logic              sb_err_q;

    logic              accept, mis, push, pop, ld_go;
    logic [WA-1:0]     req_waddr;
    logic [OFF-1:0]    req_lane;
    logic [NB-1:0]     req_mask;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    assign req_waddr     = lsu.req_addr[ADDR_W-1:OFF];
    assign req_lane      = lsu.req_addr[OFF-1:0];
    assign req_mask      = lane_mask(req_lane, lsu.req_size);
    assign lsu.req_ready = !rst && (state_q == IDLE) && (cnt_q < CW'(SB_DEPTH));
    assign accept        = lsu.req_valid && lsu.req_ready;
    assign push          = accept && lsu.req_we && !mis;
    assign ld_go         = accept && !lsu.req_we && !mis;
    assign pop           = (state_q != LD_BUS) && (cnt_q != '0) && lsu.bus_ack;

    // Misalignment: address not a multiple of the size, or dword on a 32-bit bus.
    always_comb begin
        mis = 1'b0;
        case (lsu.req_size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = lsu.req_addr[0];
            2'd2:    mis = |lsu.req_addr[1:0];
            default: mis = (DATA_W == 32) || (|lsu.req_addr[2:0]);
        endcase
    end

`ifdef LSU_STORE_FWD_EN
    logic [PW-1:0] fwd_idx;
    // Oldest-to-youngest scan so the youngest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int unsigned k = 0; k < SB_DEPTH; k++) begin
            fwd_idx = rd_ptr_q + PW'(k);
            if ((CW'(k) < cnt_q) && (sb_addr[fwd_idx] == req_waddr)) begin
                fwd_hit  = ((sb_mask[fwd_idx] & req_mask) == req_mask);
                fwd_data = sb_data[fwd_idx];
            end
        end
    end
`else
    // No forwarding: every load drains the buffer first.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
    end
`endif

    // Next-state logic for the load path.
    always_comb begin
        state_d = state_q;
        case (state_q)
            // An empty buffer skips LD_DRAIN so the bus read starts one cycle after accept.
            IDLE:     if (ld_go && !fwd_hit) state_d = (cnt_q == '0) ? LD_BUS : LD_DRAIN;
            LD_DRAIN: if (cnt_q == '0) state_d = LD_BUS;
            LD_BUS:   if (lsu.bus_ack) state_d = LD_RESP;
            default:  state_d = IDLE;
        endcase
    end

    // Bus master mux: pending load read has priority, otherwise the buffer head.
    always_comb begin
        lsu.bus_req   = 1'b0;
        lsu.bus_we    = 1'b0;
        lsu.bus_addr  = '0;
        lsu.bus_wdata = '0;
        lsu.bus_mask  = '0;
        if (!rst) begin
            if (state_q == LD_BUS) begin
                lsu.bus_req  = 1'b1;
                lsu.bus_addr = ld_waddr_q;
                lsu.bus_mask = lane_mask(ld_lane_q, ld_size_q);
            end else if (cnt_q != '0) begin
                lsu.bus_req   = 1'b1;
                lsu.bus_we    = 1'b1;
                lsu.bus_addr  = sb_addr[rd_ptr_q];
                lsu.bus_wdata = sb_data[rd_ptr_q];
                lsu.bus_mask  = sb_mask[rd_ptr_q];
            end
        end
    end

    // Response mux: bus load completion or a quick (misaligned/forwarded) response.
    always_comb begin
        lsu.resp_valid = 1'b0;
        lsu.resp_data  = '0;
        lsu.resp_rd    = '0;
        lsu.resp_err   = 1'b0;
        if (!rst) begin
            if (state_q == LD_RESP) begin
                lsu.resp_valid = 1'b1;
                lsu.resp_rd    = ld_rd_q;
                lsu.resp_err   = ld_err_q;
                lsu.resp_data  = ld_err_q ? '0 : extract(ld_raw_q, ld_lane_q, ld_size_q, ld_sgn_q);
            end else if (qr_valid_q) begin
                lsu.resp_valid = 1'b1;
                lsu.resp_rd    = qr_rd_q;
                lsu.resp_err   = qr_err_q;
                lsu.resp_data  = qr_data_q;
            end
        end
    end

    assign lsu.sb_err   = !rst && sb_err_q;
    assign lsu.sb_count = rst ? '0 : cnt_q;

    // Control state, buffer pointers, load capture and quick-response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            qr_valid_q <= 1'b0;
            sb_err_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sb_err_q <= pop && lsu.bus_err;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
            qr_valid_q <= accept && (mis || (!lsu.req_we && fwd_hit));
            qr_err_q   <= mis;
            qr_rd_q    <= lsu.req_rd;
            qr_data_q  <= mis ? '0 : extract(fwd_data, req_lane, lsu.req_size, lsu.req_signed);
            if (ld_go) begin
                ld_waddr_q <= req_waddr;
                ld_lane_q  <= req_lane;
                ld_size_q  <= lsu.req_size;
                ld_sgn_q   <= lsu.req_signed;
                ld_rd_q    <= lsu.req_rd;
            end
            if ((state_q == LD_BUS) && lsu.bus_ack) begin
                ld_raw_q <= lsu.bus_rdata;
                ld_err_q <= lsu.bus_err;
            end
        end
    end

    // Store buffer storage: lane-aligned data and byte mask per entry.
    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[wr_ptr_q] <= req_waddr;
            sb_data[wr_ptr_q] <= lsu.req_wdata << {req_lane, 3'b000};
            sb_mask[wr_ptr_q] <= req_mask;
        end
    end
endmodule

// File: tb/tb_jpu_lsu.sv
// Directed self-checking bench for jpu_lsu (32- and 64-bit instances).
module tb_jpu_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    jpu_lsu_if #(.DATA_W(32), .ADDR_W(32), .SB_DEPTH(4)) i32 ();
    jpu_lsu_if #(.DATA_W(64), .ADDR_W(32), .SB_DEPTH(4)) i64 ();

    jpu_lsu #(.DATA_W(32), .ADDR_W(32), .SB_DEPTH(4)) u32 (.clk(clk), .rst(rst), .lsu(i32.slave));
    jpu_lsu #(.DATA_W(64), .ADDR_W(32), .SB_DEPTH(4)) u64 (.clk(clk), .rst(rst), .lsu(i64.slave));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic req32(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        i32.req_valid = 1'b1; i32.req_we = we; i32.req_size = size; i32.req_signed = sgn;
        i32.req_addr = addr; i32.req_wdata = wdata; i32.req_rd = rd;
    endtask

    task automatic req64(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [63:0] wdata, input logic [4:0] rd);
        i64.req_valid = 1'b1; i64.req_we = we; i64.req_size = size; i64.req_signed = sgn;
        i64.req_addr = addr; i64.req_wdata = wdata; i64.req_rd = rd;
    endtask

    // Load with empty buffer and single-cycle ack: bus_req at T+1, resp at T+2.
    task automatic load32(input string tag, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
        req32(1'b0, size, sgn, addr, 32'h0, 5'd3);
        tick();
        i32.req_valid = 1'b0;
        check({tag, "_breq"}, i32.bus_req, 1);
        check({tag, "_bwe"}, i32.bus_we, 0);
        check({tag, "_baddr"}, i32.bus_addr, addr >> 2);
        i32.bus_ack = 1'b1; i32.bus_rdata = rdata;
        tick();
        i32.bus_ack = 1'b0;
        check({tag, "_rvalid"}, i32.resp_valid, 1);
        check({tag, "_rdata"}, i32.resp_data, exp);
        check({tag, "_rerr"}, i32.resp_err, 0);
        tick();
        check({tag, "_rdone"}, i32.resp_valid, 0);
    endtask

    task automatic load64(input string tag, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                          input logic [63:0] rdata, input logic [63:0] exp);
        req64(1'b0, size, sgn, addr, 64'h0, 5'd2);
        tick();
        i64.req_valid = 1'b0;
        check({tag, "_breq"}, i64.bus_req, 1);
        check({tag, "_baddr"}, i64.bus_addr, addr >> 3);
        i64.bus_ack = 1'b1; i64.bus_rdata = rdata;
        tick();
        i64.bus_ack = 1'b0;
        check({tag, "_rvalid"}, i64.resp_valid, 1);
        check({tag, "_rdata"}, i64.resp_data, exp);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i32.req_valid = 0; i32.req_we = 0; i32.req_size = 0; i32.req_signed = 0;
        i32.req_addr = 0; i32.req_wdata = 0; i32.req_rd = 0;
        i32.bus_ack = 0; i32.bus_rdata = 0; i32.bus_err = 0;
        i64.req_valid = 0; i64.req_we = 0; i64.req_size = 0; i64.req_signed = 0;
        i64.req_addr = 0; i64.req_wdata = 0; i64.req_rd = 0;
        i64.bus_ack = 0; i64.bus_rdata = 0; i64.bus_err = 0;

        // Reset state
        tick(); tick();
        check("rst_ready", i32.req_ready, 0);
        check("rst_breq", i32.bus_req, 0);
        check("rst_count", i32.sb_count, 0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", i32.req_ready, 1);
        check("post_rst_count", i32.sb_count, 0);

        // Byte store to 0x103, then word load from 0x100 behind it
        req32(1'b1, 2'd0, 1'b0, 32'h103, 32'hA5, 5'd0);
        tick();
        check("t1_count", i32.sb_count, 1);
        check("t1_breq", i32.bus_req, 1);
        check("t1_bwe", i32.bus_we, 1);
        check("t1_mask", i32.bus_mask, 4'b1000);
        check("t1_wdata", i32.bus_wdata, 32'hA500_0000);
        check("t1_baddr", i32.bus_addr, 30'h40);
        req32(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd7);
        tick();
        i32.req_valid = 1'b0;
        check("t1_hold_we", i32.bus_we, 1);
        check("t1_hold_addr", i32.bus_addr, 30'h40);
        i32.bus_ack = 1'b1;
        tick();
        i32.bus_ack = 1'b0;
        check("t1_drained", i32.sb_count, 0);
        check("t1_no_early_load", i32.bus_req, 0);
        tick();
        check("t1_ld_breq", i32.bus_req, 1);
        check("t1_ld_bwe", i32.bus_we, 0);
        check("t1_ld_baddr", i32.bus_addr, 30'h40);
        i32.bus_ack = 1'b1; i32.bus_rdata = 32'hCAFE_F00D;
        tick();
        i32.bus_ack = 1'b0;
        check("t1_rvalid", i32.resp_valid, 1);
        check("t1_rdata", i32.resp_data, 32'hCAFE_F00D);
        check("t1_rd", i32.resp_rd, 7);
        tick();
        check("t1_rdone", i32.resp_valid, 0);

        // Extension and lane extraction
        load32("hs", 2'd1, 1'b1, 32'h102, 32'h8001_1234, 32'hFFFF_8001);
        load32("hu", 2'd1, 1'b0, 32'h102, 32'h8001_1234, 32'h0000_8001);
        load32("bs", 2'd0, 1'b1, 32'h101, 32'h0000_8000, 32'hFFFF_FF80);

        // Misaligned word store: error response, no bus access
        req32(1'b1, 2'd2, 1'b0, 32'h101, 32'h1122_3344, 5'd9);
        tick();
        i32.req_valid = 1'b0;
        check("mis_rvalid", i32.resp_valid, 1);
        check("mis_rerr", i32.resp_err, 1);
        check("mis_rdata", i32.resp_data, 0);
        check("mis_rd", i32.resp_rd, 9);
        check("mis_breq", i32.bus_req, 0);
        check("mis_count", i32.sb_count, 0);
        tick();
        check("mis_rdone", i32.resp_valid, 0);

        // Dword on the 32-bit bus is always misaligned
        req32(1'b0, 2'd3, 1'b0, 32'h8, 32'h0, 5'd4);
        tick();
        i32.req_valid = 1'b0;
        check("dw32_rerr", i32.resp_err, 1);
        check("dw32_breq", i32.bus_req, 0);
        tick();

        // Fill buffer with ack held low
        for (int k = 0; k < 4; k++) begin
            check("fill_ready", i32.req_ready, 1);
            req32(1'b1, 2'd2, 1'b0, 32'h200 + 32'(4 * k), 32'(k), 5'd0);
            tick();
        end
        req32(1'b1, 2'd2, 1'b0, 32'h210, 32'h55, 5'd0);
        check("full_ready", i32.req_ready, 0);
        check("full_count", i32.sb_count, 4);
        check("full_head", i32.bus_addr, 30'h80);
        i32.bus_ack = 1'b1;
        tick();
        i32.bus_ack = 1'b0;
        check("one_ack_count", i32.sb_count, 3);
        check("one_ack_ready", i32.req_ready, 1);
        tick();
        i32.req_valid = 1'b0;
        check("fifth_count", i32.sb_count, 4);
        check("fifth_head", i32.bus_addr, 30'h81);
        i32.bus_ack = 1'b1; i32.bus_err = 1'b1;
        tick();
        i32.bus_err = 1'b0;
        check("sb_err_pulse", i32.sb_err, 1);
        check("drain_head", i32.bus_addr, 30'h82);
        tick();
        check("sb_err_clear", i32.sb_err, 0);
        tick();
        check("fifth_data", i32.bus_wdata, 32'h55);
        tick();
        i32.bus_ack = 1'b0;
        check("drain_count", i32.sb_count, 0);
        check("drain_breq", i32.bus_req, 0);

        // 64-bit instance
        load64("dw64", 2'd3, 1'b0, 32'h8, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        load64("ws64", 2'd2, 1'b1, 32'hC, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001);
        req64(1'b1, 2'd0, 1'b0, 32'h13, 64'hA5, 5'd0);
        tick();
        i64.req_valid = 1'b0;
        check("st64_mask", i64.bus_mask, 8'h08);
        check("st64_wdata", i64.bus_wdata, 64'hA500_0000);
        check("st64_baddr", i64.bus_addr, 29'h2);
        check("st64_count", i64.sb_count, 1);

        // Reset during LD_BUS (and with a store pending on the 64-bit unit)
        req32(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 5'd1);
        tick();
        i32.req_valid = 1'b0;
        check("rb_ldbus", i32.bus_req, 1);
        rst = 1'b1;
        tick();
        check("rb_in_rst_breq", i32.bus_req, 0);
        rst = 1'b0;
        check("rb_breq", i32.bus_req, 0);
        check("rb_rvalid", i32.resp_valid, 0);
        check("rb_count", i32.sb_count, 0);
        check("rb_count64", i64.sb_count, 0);
        tick();
        check("rb_rvalid2", i32.resp_valid, 0);
        check("rb_breq2", i32.bus_req, 0);

        // Word store then word load to the same address
        req32(1'b1, 2'd2, 1'b0, 32'h300, 32'hDEAD_BEEF, 5'd0);
        tick();
        req32(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 5'd6);
        tick();
        i32.req_valid = 1'b0;
`ifdef LSU_STORE_FWD_EN
        check("fwd_rvalid", i32.resp_valid, 1);
        check("fwd_rdata", i32.resp_data, 32'hDEAD_BEEF);
        check("fwd_rd", i32.resp_rd, 6);
        check("fwd_bwe", i32.bus_we, 1);
        check("fwd_count", i32.sb_count, 1);
        i32.bus_ack = 1'b1;
        tick();
        i32.bus_ack = 1'b0;
        check("fwd_drained", i32.sb_count, 0);
        check("fwd_no_read", i32.bus_req, 0);
        check("fwd_rdone", i32.resp_valid, 0);
`else
        check("nofwd_rvalid", i32.resp_valid, 0);
        check("nofwd_bwe", i32.bus_we, 1);
        i32.bus_ack = 1'b1;
        tick();
        i32.bus_ack = 1'b0;
        check("nofwd_wait", i32.bus_req, 0);
        tick();
        check("nofwd_breq", i32.bus_req, 1);
        check("nofwd_read", i32.bus_we, 0);
        i32.bus_ack = 1'b1; i32.bus_rdata = 32'hDEAD_BEEF;
        tick();
        i32.bus_ack = 1'b0;
        check("nofwd_rvalid2", i32.resp_valid, 1);
        check("nofwd_rdata", i32.resp_data, 32'hDEAD_BEEF);
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
